inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Instruction encoder: the inverse of the core's opcode decode control.
- Accepts field-level instruction requests (kind, registers, funct fields, immediate) over a valid/ready handshake.
- Assembles the matching 32-bit RV32I word and buffers it in a small FIFO.
- The FIFO feeds an instruction-injection port: debug program buffer, boot sequencer or self-test stimulus into the fetch stage.

Parameters:
- DEPTH, 4, output FIFO entries. Power of two, 2..16.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous FIFO clear
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_kind_i  in  4  0=R, 1=I, 2=LOAD, 3=STORE, 4=B, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC, 9=SYSTEM; 10-15 invalid
- req_rd_i  in  5  destination register
- req_rs1_i  in  5  source register 1
- req_rs2_i  in  5  source register 2
- req_funct3_i  in  3  funct3
- req_funct7_i  in  7  funct7 (R only)
- req_imm_i  in  32  immediate, byte-offset form
- inst_valid_o  out  1  head entry valid
- inst_ready_i  in  1  consumer ready
- inst_o  out  32  encoded instruction at FIFO head
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- err_o  out  1  one-cycle pulse on rejected request
- err_count_o  out  CNT_W  saturating count of rejected requests

Behaviour:
- Reset (async, reset_n=0): FIFO empty, count_o=0, inst_valid_o=0, inst_o=0, err_o=0, err_count_o=0, req_ready_o=0 while in reset.
- Opcodes:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, B 1100011
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011
- Field placement:
  - rd [11:7] for R/I/LOAD/JALR/LUI/AUIPC/JAL/SYSTEM.
  - rs1 [19:15] and funct3 [14:12] for all except LUI/AUIPC/JAL.
  - rs2 [24:20] for R/STORE/B.
  - funct7 [31:25] for R.
  - Unused fields are forced to 0.
- Immediate packing:
  - I/LOAD/JALR/SYSTEM: imm[11:0] to [31:20]. Shifts carry funct7 in imm[11:5].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: imm[12] to 31, imm[10:5] to 30:25, imm[4:1] to 11:8, imm[11] to 7.
  - U: imm[31:12] to [31:12].
  - J: imm[20] to 31, imm[10:1] to 30:21, imm[11] to 20, imm[19:12] to 19:12.
- Handshake: req_ready_o = (count < DEPTH). A request is accepted when req_valid_i && req_ready_o. There is no full-bypass: with the FIFO full, req_ready_o stays 0 even if a pop occurs in the same cycle.
- Latency: an accepted valid request is written into the FIFO at the clock edge. If the FIFO was empty, inst_valid_o=1 and inst_o holds the encoded word the next cycle. Encoding is combinational on the request fields.
- Pop: occurs when inst_valid_o && inst_ready_i. Simultaneous push and pop when not full leaves count unchanged. Pointers wrap modulo DEPTH.
- inst_o is 0 when the FIFO is empty. Head data is stable while inst_valid_o=1 and inst_ready_i=0.
- Invalid kind (10-15):
  - The request is accepted (handshake completes) and nothing is pushed.
  - err_o pulses high for one cycle after acceptance.
  - err_count_o increments and saturates at 2^CNT_W-1.
- flush_i:
  - Next cycle count=0 and inst_valid_o=0.
  - Flush has priority over push and pop in the same cycle; a request accepted in a flush cycle is discarded, with no error.
  - err_count_o is not cleared by flush.
- Reset mid-stream: all FIFO contents are lost immediately. There is no partial output.

Optional Feature:
- INST_ENC_RANGE_CHECK_EN defined: a request is rejected and handled like an invalid kind (no push, err_o pulse, counter increment) when any of the following holds:
  - I/S-class immediate is not representable as signed 12-bit.
  - B immediate is not signed 13-bit, or imm[0]=1.
  - J immediate is not signed 21-bit, or imm[0]=1.
  - U immediate has imm[11:0]!=0.
- Undefined: out-of-range bits are silently truncated per the packing rules and the word is pushed.

Test Plan:
- Single encodes, each followed by a pop; inst_o must equal:
  - I kind=1 rd=1 rs1=2 f3=0 imm=5 -> 0x00510093
  - R kind=0 rd=3 rs1=1 rs2=2 f3=0 f7=0 -> 0x002081B3
  - STORE kind=3 rs1=2 rs2=5 f3=2 imm=8 -> 0x00512423
- Branch/jump/upper:
  - B kind=4 rs1=0 rs2=0 f3=0 imm=-4 -> 0xFE000EE3
  - JAL kind=5 rd=1 imm=0x800 -> 0x001000EF
  - LUI kind=7 rd=5 imm=0x12345000 -> 0x123452B7
- Fill: DEPTH=4, inst_ready_i=0, 5 back-to-back requests -> req_ready_o low after 4th accept, count_o=4. Then inst_ready_i=1 -> words pop in order, count reaches 0, inst_valid_o=0.
- Invalid kind=12 -> handshake completes, err_o one-cycle pulse, err_count_o 0 to 1, count_o unchanged. Repeat 300 times with CNT_W=8 -> saturates at 255.
- flush_i asserted with count=3 and a simultaneous request -> next cycle count_o=0, inst_valid_o=0, no err_o; async reset_n low mid-stream -> all outputs return to reset values immediately.
- With INST_ENC_RANGE_CHECK_EN: I kind=1 imm=2048 -> rejected, err_o pulse; B imm=3 -> rejected. Without the macro: I imm=2048 pushes 0x80000013 (rd=rs1=0).

Source files
------------

// File: rtl/inst_encoder_if.sv
// Request/injection bus of the instruction encoder: field-level request in,
// encoded RV32I word out, plus occupancy and error status.
interface inst_encoder_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Both channels use valid/ready: a transfer happens on a rising clock edge
  // where valid and ready are both high; the producer holds its payload
  // stable while valid is high and ready is low.
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        req_kind_i;
  logic [4:0]        req_rd_i;
  logic [4:0]        req_rs1_i;
  logic [4:0]        req_rs2_i;
  logic [2:0]        req_funct3_i;
  logic [6:0]        req_funct7_i;
  logic [31:0]       req_imm_i;

  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [31:0]       inst_o;

  logic [CW-1:0]     count_o;
  logic              err_o;
  logic [CNT_W-1:0]  err_count_o;

  modport master (
    output req_valid_i, req_kind_i, req_rd_i, req_rs1_i, req_rs2_i,
           req_funct3_i, req_funct7_i, req_imm_i, inst_ready_i,
    input  req_ready_o, inst_valid_o, inst_o, count_o, err_o, err_count_o
  );

  modport slave (
    input  req_valid_i, req_kind_i, req_rd_i, req_rs1_i, req_rs2_i,
           req_funct3_i, req_funct7_i, req_imm_i, inst_ready_i,
    output req_ready_o, inst_valid_o, inst_o, count_o, err_o, err_count_o
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder feeding a DEPTH-entry injection FIFO.
// Optional macro INST_ENC_RANGE_CHECK_EN rejects out-of-range immediates.
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  inst_encoder_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [31:0] imm;
  logic [31:0] imm_bits;
  logic [31:0] word;
  logic        imm_ok;
  logic        use_rd, use_rs1, use_rs2, use_f7;

  logic [31:0]      mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt;

  logic req_ready, accept, good, push, pop, err_d, head_valid;

  assign imm = bus.req_imm_i;

  always_comb begin
    opcode = 7'b0;
    fmt    = FMT_NONE;
    case (bus.req_kind_i)
      4'd0:    begin opcode = 7'b0110011; fmt = FMT_R; end
      4'd1:    begin opcode = 7'b0010011; fmt = FMT_I; end
      4'd2:    begin opcode = 7'b0000011; fmt = FMT_I; end
      4'd3:    begin opcode = 7'b0100011; fmt = FMT_S; end
      4'd4:    begin opcode = 7'b1100011; fmt = FMT_B; end
      4'd5:    begin opcode = 7'b1101111; fmt = FMT_J; end
      4'd6:    begin opcode = 7'b1100111; fmt = FMT_I; end
      4'd7:    begin opcode = 7'b0110111; fmt = FMT_U; end
      4'd8:    begin opcode = 7'b0010111; fmt = FMT_U; end
      4'd9:    begin opcode = 7'b1110011; fmt = FMT_I; end
      default: ;
    endcase
  end

  assign use_rd  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  assign use_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign use_f7  = (fmt == FMT_R);

  // Immediate bits only land on positions whose register fields are zeroed
  // for that format, so the word can be OR-composed.
  always_comb begin
    imm_bits = 32'b0;
    case (fmt)
      FMT_I:   imm_bits = {imm[11:0], 20'b0};
      FMT_S:   imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      FMT_B:   imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      FMT_U:   imm_bits = {imm[31:12], 12'b0};
      FMT_J:   imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      default: imm_bits = 32'b0;
    endcase
  end

  always_comb begin
    imm_ok = 1'b1;
`ifdef INST_ENC_RANGE_CHECK_EN
    case (fmt)
      FMT_I, FMT_S: imm_ok = (&imm[31:11]) || ~(|imm[31:11]);
      FMT_B:        imm_ok = ((&imm[31:12]) || ~(|imm[31:12])) && !imm[0];
      FMT_J:        imm_ok = ((&imm[31:20]) || ~(|imm[31:20])) && !imm[0];
      FMT_U:        imm_ok = ~(|imm[11:0]);
      default:      imm_ok = 1'b1;
    endcase
`endif
  end

  assign word = imm_bits
              | {use_f7 ? bus.req_funct7_i : 7'b0,
                 use_rs2 ? bus.req_rs2_i : 5'b0,
                 use_rs1 ? bus.req_rs1_i : 5'b0,
                 use_rs1 ? bus.req_funct3_i : 3'b0,
                 use_rd  ? bus.req_rd_i : 5'b0,
                 opcode};

  // Ready is held low during reset and never bypasses a full FIFO.
  assign req_ready  = reset_n && (count < FULL);
  assign head_valid = (count != '0);
  assign accept     = bus.req_valid_i && req_ready;
  assign good       = (fmt != FMT_NONE) && imm_ok;
  assign push       = accept && good && !flush_i;
  assign err_d      = accept && !good && !flush_i;
  assign pop        = head_valid && bus.inst_ready_i && !flush_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= err_d;
      if (err_d && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.inst_valid_o = head_valid;
  assign bus.inst_o       = head_valid ? mem[rd_ptr] : 32'b0;
  assign bus.count_o      = count;
  assign bus.err_o        = err_q;
  assign bus.err_count_o  = err_cnt;
endmodule
